// File: rtl/window_scheduler.sv
// Raster-scan window sequencer: walks every detection-window origin, hands it to the classifier, and streams out accepted origins.
// Optional WINDOW_SCHED_STATS_EN adds saturating win_count/det_count outputs.
module window_scheduler #(
  parameter int unsigned IMG_WIDTH  = 320,
  parameter int unsigned IMG_HEIGHT = 240,
  parameter int unsigned WIN_SIZE   = 25,
  parameter int unsigned STEP       = 1,
  localparam int unsigned W_X = $clog2(IMG_WIDTH),
  localparam int unsigned W_Y = $clog2(IMG_HEIGHT)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  output logic           busy,
  output logic           done,
  output logic           win_valid,
  input  logic           win_ready,
  output logic [W_X-1:0] win_x,
  output logic [W_Y-1:0] win_y,
  input  logic           result_valid,
  output logic           result_ready,
  input  logic           result_data,
  output logic           det_valid,
  input  logic           det_ready,
  output logic [W_X-1:0] det_x,
  output logic [W_Y-1:0] det_y
`ifdef WINDOW_SCHED_STATS_EN
  ,
  output logic [31:0]    win_count,
  output logic [31:0]    det_count
`endif
);

  localparam int unsigned X_LAST = IMG_WIDTH - WIN_SIZE;
  localparam int unsigned Y_LAST = IMG_HEIGHT - WIN_SIZE;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_ADV   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  if (IMG_WIDTH < WIN_SIZE || IMG_HEIGHT < WIN_SIZE) begin : g_bad_geometry
    $error("window_scheduler: image %0dx%0d smaller than window %0d",
           IMG_WIDTH, IMG_HEIGHT, WIN_SIZE);
  end
  if (STEP < 1) begin : g_bad_step
    $error("window_scheduler: STEP must be at least 1");
  end

  logic [2:0]     state_q, state_d;
  logic [W_X-1:0] x_q, x_d;
  logic [W_Y-1:0] y_q, y_d;
  logic [W_X-1:0] det_x_q, det_x_d;
  logic [W_Y-1:0] det_y_q, det_y_d;

  logic           res_hs;
  logic           det_hs;
  logic           x_fits;
  logic           y_fits;
  int unsigned    x_ext;
  int unsigned    y_ext;

  assign res_hs = (state_q == S_WAIT) && result_valid;
  assign det_hs = (state_q == S_EMIT) && det_ready;

  // Compare in 32 bits before adding so the origin counters never wrap.
  always_comb begin
    x_ext  = 32'(x_q);
    y_ext  = 32'(y_q);
    x_fits = (x_ext + STEP) <= X_LAST;
    y_fits = (y_ext + STEP) <= Y_LAST;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    det_x_d = det_x_q;
    det_y_d = det_y_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = '0;
          y_d     = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (win_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (result_valid) begin
          if (result_data) begin
            det_x_d = x_q;
            det_y_d = y_q;
            state_d = S_EMIT;
          end else begin
            state_d = S_ADV;
          end
        end
      end
      S_EMIT: begin
        if (det_ready) state_d = S_ADV;
      end
      S_ADV: begin
        if (x_fits) begin
          x_d     = W_X'(x_ext + STEP);
          state_d = S_ISSUE;
        end else if (y_fits) begin
          x_d     = '0;
          y_d     = W_Y'(y_ext + STEP);
          state_d = S_ISSUE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over start and every handshake: freeze datapath, drop to IDLE.
    if (abort) begin
      state_d = S_IDLE;
      x_d     = x_q;
      y_d     = y_q;
      det_x_d = det_x_q;
      det_y_d = det_y_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      det_x_q <= '0;
      det_y_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      det_x_q <= det_x_d;
      det_y_q <= det_y_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign win_valid    = (state_q == S_ISSUE);
  assign result_ready = (state_q == S_WAIT);
  assign det_valid    = (state_q == S_EMIT);
  assign win_x        = x_q;
  assign win_y        = y_q;
  assign det_x        = det_x_q;
  assign det_y        = det_y_q;

`ifdef WINDOW_SCHED_STATS_EN
  logic [31:0] win_count_q, win_count_d;
  logic [31:0] det_count_q, det_count_d;

  // Counters hold across abort; only an accepted start clears them.
  always_comb begin
    win_count_d = win_count_q;
    det_count_d = det_count_q;
    if (!abort) begin
      if (state_q == S_IDLE && start) begin
        win_count_d = '0;
        det_count_d = '0;
      end
      if (res_hs && win_count_q != '1) win_count_d = win_count_q + 32'd1;
      if (det_hs && det_count_q != '1) det_count_d = det_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_count_q <= '0;
      det_count_q <= '0;
    end else begin
      win_count_q <= win_count_d;
      det_count_q <= det_count_d;
    end
  end

  assign win_count = win_count_q;
  assign det_count = det_count_q;
`else
  logic unused_hs;
  assign unused_hs = res_hs ^ det_hs;
`endif

endmodule
